// File: rtl/sdram_bist.sv
// Built-in self-test for the SDRAM system port: pattern fill, read-back, compare.
// Define SDRAM_BIST_ALLMODES_EN to run all four patterns back to back per start.
module sdram_bist #(
  parameter int ADDR_W    = 22,
  parameter int DATA_W    = 16,
  parameter int ERR_W     = 16,
  parameter int TIMEOUT_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] addr_lo,
  input  logic [ADDR_W-1:0] addr_hi,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_got,
  output logic [ADDR_W-1:0] sys_addr,
  output logic [DATA_W-1:0] sys_data_to_sdram,
  output logic              sys_write_rq,
  output logic              sys_read_rq,
  input  logic              sys_write_done,
  input  logic              sys_data_from_sdram_valid,
  input  logic [DATA_W-1:0] sys_data_from_sdram
);

  localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {IDLE, WRITE, WGAP, READ, RGAP, FINISH} state_t;
  state_t state, state_nx;

  logic [1:0]           mode_r;
  logic [ADDR_W-1:0]    lo_r, hi_r, cur;
  logic [31:0]          lfsr;
  logic                 range_ok;
  logic [TIMEOUT_W-1:0] tcnt;
  logic                 wr_ack, rd_ack, tmo, at_end, empty, mismatch, last_pass;
  logic [DATA_W-1:0]    exp_d;
  logic                 busy_d, done_d, wr_rq_d, rd_rq_d;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {1'b0, l[31:1]} ^ (l[0] ? LFSR_TAPS : 32'h0);
  endfunction

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [ADDR_W-1:0] a,
                                                input logic [31:0] l);
    case (m)
      2'd0:    return DATA_W'(a);
      2'd1:    return ~DATA_W'(a);
      2'd2:    return DATA_W'(1) << (a % ADDR_W'(DATA_W));
      default: return l[DATA_W-1:0];
    endcase
  endfunction

  // Acks only count while our registered request is actually visible to the controller.
  always_comb begin
    wr_ack   = (state == WRITE) && sys_write_rq && sys_write_done;
    rd_ack   = (state == READ) && sys_read_rq && sys_data_from_sdram_valid;
    tmo      = (((state == WRITE) && sys_write_rq && !sys_write_done) ||
                ((state == READ) && sys_read_rq && !sys_data_from_sdram_valid)) &&
               (tcnt == TMO_LAST);
    at_end   = (cur == hi_r);
    empty    = (addr_hi < addr_lo);
    exp_d    = pattern(mode_r, cur, lfsr);
    mismatch = rd_ack && (sys_data_from_sdram != exp_d);
`ifdef SDRAM_BIST_ALLMODES_EN
    last_pass = (mode_r == 2'd3);
`else
    last_pass = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (start) state_nx = empty ? FINISH : WRITE;
      WRITE:  if (tmo) state_nx = FINISH; else if (wr_ack) state_nx = WGAP;
      WGAP:   state_nx = at_end ? READ : WRITE;
      READ:   if (tmo) state_nx = FINISH; else if (rd_ack) state_nx = RGAP;
      RGAP:   state_nx = at_end ? (last_pass ? FINISH : WRITE) : READ;
      FINISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request is cleared in the same edge as the timeout so it drops after exactly the limit.
  always_comb begin
    busy_d  = (state == WRITE) || (state == WGAP) || (state == READ) || (state == RGAP);
    done_d  = (state == FINISH);
    wr_rq_d = (state == WRITE) && !tmo;
    rd_rq_d = (state == READ) && !tmo;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0; done <= 1'b0; pass <= 1'b0; timeout <= 1'b0;
      err_count <= '0; first_err_addr <= '0; first_err_exp <= '0; first_err_got <= '0;
      sys_addr <= '0; sys_data_to_sdram <= '0; sys_write_rq <= 1'b0; sys_read_rq <= 1'b0;
      mode_r <= '0; lo_r <= '0; hi_r <= '0; cur <= '0; lfsr <= '0; range_ok <= 1'b0; tcnt <= '0;
    end else begin
      busy              <= busy_d;
      done              <= done_d;
      sys_write_rq      <= wr_rq_d;
      sys_read_rq       <= rd_rq_d;
      sys_addr          <= cur;
      sys_data_to_sdram <= exp_d;
      tcnt <= (((state == WRITE) && sys_write_rq) || ((state == READ) && sys_read_rq)) &&
              !wr_ack && !rd_ack ? tcnt + 1'b1 : '0;
      case (state)
        IDLE: if (start) begin
`ifdef SDRAM_BIST_ALLMODES_EN
          mode_r <= 2'd0;
`else
          mode_r <= mode;
`endif
          lo_r <= addr_lo; hi_r <= addr_hi; cur <= addr_lo; lfsr <= LFSR_SEED;
          range_ok <= !empty;
          err_count <= '0; first_err_addr <= '0; first_err_exp <= '0; first_err_got <= '0;
          pass <= 1'b0; timeout <= 1'b0;
        end
        WRITE: begin
          if (wr_ack) lfsr <= lfsr_step(lfsr);
          if (tmo) timeout <= 1'b1;
        end
        WGAP: begin
          if (at_end) begin cur <= lo_r; lfsr <= LFSR_SEED; end
          else cur <= cur + 1'b1;
        end
        READ: begin
          if (rd_ack) lfsr <= lfsr_step(lfsr);
          if (mismatch) begin
            if (err_count != '1) err_count <= err_count + 1'b1;
            if (err_count == '0) begin
              first_err_addr <= cur; first_err_exp <= exp_d; first_err_got <= sys_data_from_sdram;
            end
          end
          if (tmo) timeout <= 1'b1;
        end
        RGAP: begin
          if (!at_end) cur <= cur + 1'b1;
          else if (!last_pass) begin
            mode_r <= mode_r + 2'd1; cur <= lo_r; lfsr <= LFSR_SEED;
          end
        end
        FINISH: pass <= range_ok && (err_count == '0) && !timeout;
        default: ;
      endcase
    end
  end

endmodule
